// File: rtl/img_window_if.sv
//============================================================================
// Module      : img_window_if
// Description : Bundles the pixel stream (pix_*), the downstream back-pressure
//               input (hold) and the parallel window bus (img/val/row_first/
//               short_row) that surround img_window.
//               master : environment side. Drives the pixels and hold, and
//                        observes the window bus.
//               slave  : img_window side.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface img_window_if #(
  parameter int IMG_WIDTH = 16,
  parameter int IMG_NB    = 3
);

  logic [IMG_WIDTH-1:0]        pix_data;
  logic                        pix_valid;
  logic                        pix_last;
  logic                        pix_ready;
  logic                        hold;
  logic [IMG_WIDTH*IMG_NB-1:0] img;
  logic                        val;
  logic                        row_first;
  logic                        short_row;

  modport master (
    output pix_data, pix_valid, pix_last, hold,
    input  pix_ready, img, val, row_first, short_row
  );

  modport slave (
    input  pix_data, pix_valid, pix_last, hold,
    output pix_ready, img, val, row_first, short_row
  );

endinterface

`default_nettype wire

// File: rtl/img_window.sv
//============================================================================
// Module      : img_window
// Description : Builds a sliding window of IMG_NB consecutive same-row pixels
//               from a serial valid/ready pixel stream, and presents each
//               window on the parallel img/val bus of the convolution engine.
//
//   Parameters : IMG_WIDTH - bits per pixel
//                IMG_NB    - window length in taps (>= 2)
//   Ports      : clk - rising-edge clock
//                rst - asynchronous, active-low reset
//                bus - img_window_if.slave
//                      pix_data/pix_valid/pix_last in, pix_ready out
//                      hold in
//                      img/val/row_first/short_row out, all registered
//   Build macro: IMG_WINDOW_PAD_EN. When it is defined, the block performs
//                zero-padded ("full") convolution and adds a FLUSH state.
//                When it is undefined, only "valid" windows are produced.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module img_window #(
  parameter int IMG_WIDTH = 16,
  parameter int IMG_NB    = 3
) (
  input  logic         clk,
  input  logic         rst,
  img_window_if.slave  bus
);

  localparam int                 FILL_W   = $clog2(IMG_NB) + 1;
  localparam int                 WIN_W    = IMG_WIDTH * IMG_NB;
  localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(IMG_NB - 1);

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
`ifdef IMG_WINDOW_PAD_EN
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  // While in FLUSH, fill counts the zero pixels shifted in so far.
  // The flush ends on the shift made with this count.
  localparam logic [FILL_W-1:0] FLUSH_LAST = FILL_W'(IMG_NB - 2);
`endif

  logic [1:0]        state_q,     state_d;
  logic [FILL_W-1:0] fill_q,      fill_d;
  logic [WIN_W-1:0]  win_q,       win_d;
  logic [WIN_W-1:0]  img_q,       img_d;
  logic              val_q,       val_d;
  logic              row_first_q, row_first_d;
  logic              short_row_q, short_row_d;

  logic              accept;
  logic [WIN_W-1:0]  win_shift;

  // ------------------------------------------------------------------
  // Handshake
  // ------------------------------------------------------------------
  always_comb begin
    bus.pix_ready = rst & ~bus.hold;
`ifdef IMG_WINDOW_PAD_EN
    if (state_q == ST_FLUSH) begin
      bus.pix_ready = 1'b0;
    end
`endif
  end

  assign accept = bus.pix_valid & bus.pix_ready;

  // Slice IMG_NB-1 (top) takes the new pixel, and every other slice takes
  // its younger neighbour.
  assign win_shift = {bus.pix_data, win_q[WIN_W-1:IMG_WIDTH]};

  // ------------------------------------------------------------------
  // State register (all flops)
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FILL;
      fill_q      <= '0;
      win_q       <= '0;
      img_q       <= '0;
      val_q       <= 1'b0;
      row_first_q <= 1'b0;
      short_row_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      win_q       <= win_d;
      img_q       <= img_d;
      val_q       <= val_d;
      row_first_q <= row_first_d;
      short_row_q <= short_row_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
`ifdef IMG_WINDOW_PAD_EN
          state_d = bus.pix_last ? ST_FLUSH : ST_STREAM;
`else
          if (bus.pix_last) begin
            state_d = ST_FILL;
          end else if (fill_q == FILL_MAX) begin
            state_d = ST_STREAM;
          end
`endif
        end
      end
      ST_STREAM: begin
        if (accept && bus.pix_last) begin
`ifdef IMG_WINDOW_PAD_EN
          state_d = ST_FLUSH;
`else
          state_d = ST_FILL;
`endif
        end
      end
`ifdef IMG_WINDOW_PAD_EN
      ST_FLUSH: begin
        if (!bus.hold && (fill_q == FLUSH_LAST)) begin
          state_d = ST_FILL;
        end
      end
`endif
      default: state_d = ST_FILL;
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath and output logic
  // ------------------------------------------------------------------
  always_comb begin
    fill_d      = fill_q;
    win_d       = win_q;
    img_d       = img_q;
    val_d       = 1'b0;
    row_first_d = 1'b0;
    short_row_d = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          win_d = win_shift;
`ifdef IMG_WINDOW_PAD_EN
          // The window starts each row all-zero, so the first pixel
          // already forms an output window.
          img_d       = win_shift;
          val_d       = 1'b1;
          row_first_d = 1'b1;
          fill_d      = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
          if (bus.pix_last) begin
            fill_d = '0;
          end
`else
          if (fill_q == FILL_MAX) begin
            img_d       = win_shift;
            val_d       = 1'b1;
            row_first_d = 1'b1;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
          if (bus.pix_last) begin
            fill_d      = '0;
            win_d       = '0;
            short_row_d = (fill_q != FILL_MAX);
          end
`endif
        end
      end

      ST_STREAM: begin
        if (accept) begin
          win_d = win_shift;
          img_d = win_shift;
          val_d = 1'b1;
          if (bus.pix_last) begin
            fill_d = '0;
`ifndef IMG_WINDOW_PAD_EN
            win_d  = '0;
`endif
          end
        end
      end

`ifdef IMG_WINDOW_PAD_EN
      ST_FLUSH: begin
        if (!bus.hold) begin
          win_d  = {{IMG_WIDTH{1'b0}}, win_q[WIN_W-1:IMG_WIDTH]};
          img_d  = win_d;
          val_d  = 1'b1;
          fill_d = fill_q + FILL_W'(1);
          if (fill_q == FLUSH_LAST) begin
            // The last shift has been emitted. Start the next row from an
            // empty window.
            fill_d = '0;
            win_d  = '0;
          end
        end
      end
`endif

      default: ;
    endcase
  end

  assign bus.img       = img_q;
  assign bus.val       = val_q;
  assign bus.row_first = row_first_q;
  assign bus.short_row = short_row_q;

endmodule

`default_nettype wire

// File: tb/tb_img_window.sv
//============================================================================
// Module      : tb_img_window
// Description : Self-checking bench for img_window. It runs directed rows
//               followed by random traffic. Each cycle is compared against a
//               row-level reference model that keeps the pixels of the
//               current row in a queue.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_img_window;

  localparam int W     = 16;
  localparam int NB    = 3;
  localparam int WIN_W = W * NB;

`ifdef IMG_WINDOW_PAD_EN
  localparam int               EXP_BASIC_N  = 7;
  localparam logic [WIN_W-1:0] EXP_BASIC_1  = 48'h0001_0000_0000;
  localparam int               EXP_SHORT_N  = 9;
  localparam int               EXP_SHORT_SR = 0;
  localparam int               EXP_RST_N    = 5;
  localparam logic [WIN_W-1:0] EXP_RST_1    = 48'h0004_0000_0000;
  localparam int               EXP_B2B_N    = 12;
`else
  localparam int               EXP_BASIC_N  = 3;
  localparam logic [WIN_W-1:0] EXP_BASIC_1  = 48'h0003_0002_0001;
  localparam int               EXP_SHORT_N  = 1;
  localparam int               EXP_SHORT_SR = 1;
  localparam int               EXP_RST_N    = 1;
  localparam logic [WIN_W-1:0] EXP_RST_1    = 48'h0006_0005_0004;
  localparam int               EXP_B2B_N    = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  img_window_if #(.IMG_WIDTH(W), .IMG_NB(NB)) bus ();

  img_window #(.IMG_WIDTH(W), .IMG_NB(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Counters that the directed segments inspect
  int               n_val   = 0;
  int               n_rf    = 0;
  int               n_sr    = 0;
  bit               first_seen = 1'b0;
  logic [WIN_W-1:0] first_img  = '0;

  // Reference model state: the pixels accepted in the current row, the
  // pending trailing zero windows, and the last window emitted.
  logic [W-1:0]     row_q[$];
  int               flush_left = 0;
  int               flush_pos  = 0;
  logic [WIN_W-1:0] m_img      = '0;

  task automatic check(input string tag, input logic [WIN_W-1:0] obs,
                       input logic [WIN_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns the window whose newest pixel has row index e. Indices that fall
  // outside the row read as zero.
  function automatic logic [WIN_W-1:0] window_at(input int e);
    logic [WIN_W-1:0] w;
    int idx;
    w = '0;
    for (int k = 0; k < NB; k++) begin
      idx = e - (NB - 1) + k;
      if (idx >= 0 && idx < row_q.size()) w[k*W +: W] = row_q[idx];
    end
    return w;
  endfunction

  function automatic void seg_start();
    n_val = 0;
    n_rf = 0;
    n_sr = 0;
    first_seen = 1'b0;
    first_img = '0;
  endfunction

  // One clock cycle: drive the inputs, predict the result, and check it.
  task automatic cycle(input bit v, input logic [W-1:0] d, input bit l,
                       input bit h, output bit acc);
    bit e_val, e_rf, e_sr, e_ready;
    bus.pix_valid = v;
    bus.pix_data  = d;
    bus.pix_last  = l;
    bus.hold      = h;
    #1;
    e_ready = rst && !h && (flush_left == 0);
    check("pix_ready", {47'b0, bus.pix_ready}, {47'b0, e_ready});
    acc   = v && e_ready;
    e_val = 1'b0;
    e_rf  = 1'b0;
    e_sr  = 1'b0;
    if (acc) begin
      row_q.push_back(d);
`ifdef IMG_WINDOW_PAD_EN
      e_val = 1'b1;
      m_img = window_at(row_q.size() - 1);
      e_rf  = (row_q.size() == 1);
      if (l) begin
        flush_left = NB - 1;
        flush_pos  = row_q.size();
      end
`else
      if (row_q.size() >= NB) begin
        e_val = 1'b1;
        m_img = window_at(row_q.size() - 1);
        e_rf  = (row_q.size() == NB);
      end
      if (l) begin
        e_sr = (row_q.size() < NB);
        row_q.delete();
      end
`endif
    end
`ifdef IMG_WINDOW_PAD_EN
    else if (flush_left > 0 && !h) begin
      e_val = 1'b1;
      m_img = window_at(flush_pos);
      flush_pos++;
      flush_left--;
      if (flush_left == 0) row_q.delete();
    end
`endif
    @(posedge clk);
    #1;
    check("val",       {47'b0, bus.val},       {47'b0, e_val});
    check("row_first", {47'b0, bus.row_first}, {47'b0, e_rf});
    check("short_row", {47'b0, bus.short_row}, {47'b0, e_sr});
    if (e_val || h) check("img", bus.img, m_img);
    if (bus.val) begin
      n_val++;
      if (bus.row_first) n_rf++;
      if (!first_seen) begin
        first_seen = 1'b1;
        first_img  = bus.img;
      end
    end
    if (bus.short_row) n_sr++;
  endtask

  task automatic send(input logic [W-1:0] d, input bit l);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      cycle(1'b1, d, l, 1'b0, acc);
      tries++;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $error("FAIL send_timeout: observed no accept expected accept within 20 cycles");
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, acc);
  endtask

  // Asserts reset with valid high, checks that all outputs are at their reset
  // values, and releases reset just after a rising edge.
  task automatic do_reset();
    rst           = 1'b0;
    bus.pix_valid = 1'b1;
    bus.pix_data  = 16'h00aa;
    bus.pix_last  = 1'b0;
    bus.hold      = 1'b0;
    row_q.delete();
    flush_left = 0;
    m_img      = '0;
    #1;
    check("rst_img",       bus.img, '0);
    check("rst_val",       {47'b0, bus.val},       '0);
    check("rst_row_first", {47'b0, bus.row_first}, '0);
    check("rst_short_row", {47'b0, bus.short_row}, '0);
    check("rst_pix_ready", {47'b0, bus.pix_ready}, '0);
    @(posedge clk);
    #1;
    check("rst_val_hold",   {47'b0, bus.val},       '0);
    check("rst_ready_hold", {47'b0, bus.pix_ready}, '0);
    rst = 1'b1;
  endtask

  initial begin
    bit acc;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.pix_last  = 1'b0;
    bus.hold      = 1'b0;

    do_reset();

    // Basic row 1..5
    seg_start();
    for (int p = 1; p <= 5; p++) send(W'(p), p == 5);
    idle(NB + 1);
    check("basic_count", WIN_W'(n_val), WIN_W'(EXP_BASIC_N));
    check("basic_first", first_img, EXP_BASIC_1);
    check("basic_rf",    WIN_W'(n_rf), WIN_W'(1));

    // Back-pressure: hold for two cycles after pixel 3
    seg_start();
    for (int p = 1; p <= 3; p++) send(W'(p), 1'b0);
    cycle(1'b1, 16'd4, 1'b0, 1'b1, acc);
    cycle(1'b1, 16'd4, 1'b0, 1'b1, acc);
    send(16'd4, 1'b0);
    send(16'd5, 1'b1);
    idle(NB + 1);
    check("bp_count", WIN_W'(n_val), WIN_W'(EXP_BASIC_N));

    // Short row 7,8, then row 1..3
    seg_start();
    send(16'd7, 1'b0);
    send(16'd8, 1'b1);
    for (int p = 1; p <= 3; p++) send(W'(p), p == 3);
    idle(NB + 1);
    check("short_count", WIN_W'(n_val), WIN_W'(EXP_SHORT_N));
    check("short_pulses", WIN_W'(n_sr), WIN_W'(EXP_SHORT_SR));
    check("short_next_img", bus.img, 48'h0000_0000_0000 |
          (EXP_SHORT_SR != 0 ? 48'h0003_0002_0001 : 48'h0000_0000_0003));

    // Reset in the middle of a row
    send(16'd1, 1'b0);
    send(16'd2, 1'b0);
    do_reset();
    seg_start();
    send(16'd4, 1'b0);
    send(16'd5, 1'b0);
    send(16'd6, 1'b1);
    idle(NB + 1);
    check("rst_mid_count", WIN_W'(n_val), WIN_W'(EXP_RST_N));
    check("rst_mid_first", first_img, EXP_RST_1);

    // Back-to-back rows 1..4 and 5..8
    seg_start();
    for (int p = 1; p <= 8; p++) send(W'(p), (p == 4) || (p == 8));
    idle(NB + 1);
    check("b2b_count", WIN_W'(n_val), WIN_W'(EXP_B2B_N));
    check("b2b_rf",    WIN_W'(n_rf), WIN_W'(2));

    // Random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, W'($urandom),
              $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, acc);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
